// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port arbiter sharing the unified memory between the
//            instruction-fetch port and the load/store data port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int MEM_BITS     = 20,
    parameter int DATA_SIZE    = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 if_req,
    input  logic [MEM_BITS-1:0]  if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [31:0]          if_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [MEM_BITS-1:0]  d_addr,
    input  logic [2:0]           d_mode,
    input  logic [DATA_SIZE-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DATA_SIZE-1:0] d_rdata,

    output logic                 mem_we,
    output logic [MEM_BITS-1:0]  mem_addr,
    output logic [2:0]           mem_mode,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [2:0] C_MODE_WU      = 3'b110;

    logic [3:0] r_starve_cnt;
    logic       w_fetch_prio;

    // Data normally wins; fetch takes priority once it has been denied
    // STARVE_LIMIT consecutive cycles.
    always_comb begin
        w_fetch_prio = (r_starve_cnt == C_STARVE_LIMIT);
        d_gnt        = d_req & ~(if_req & w_fetch_prio);
        if_gnt       = if_req & ~d_gnt;
    end

    // Idle cycles drive all zeros so memory never sees a stray write.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_mode  = 3'b000;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_mode  = d_mode;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_mode  = C_MODE_WU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
            if_rvalid    <= 1'b0;
            if_rdata     <= 32'd0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
        end else begin
            if (if_req && !if_gnt) begin
                if (r_starve_cnt != C_STARVE_LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end

            if_rvalid <= if_gnt;
            if (if_gnt) begin
                if_rdata <= mem_rdata[31:0];
            end

            d_rvalid <= d_gnt;
            if (d_gnt) begin
                d_rdata <= d_we ? '0 : mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares the core's unified `memory` buffer between the instruction-fetch port and the load/store data port. Each cycle it grants at most one requester, drives the memory address/mode/write lines from the winner, and returns read data through a registered one-cycle-latency response. Data accesses normally win. A saturating starvation counter forces a fetch grant after a bounded number of denials.

## Interface
- `MEM_BITS`, 20: memory entry-index width, matching `memory`.
- `DATA_SIZE`, 64: memory data width.
- `STARVE_LIMIT`, 4: consecutive fetch denials before fetch gets priority; legal range 1..15.

- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held until granted.
- `if_addr` in MEM_BITS: fetch entry index.
- `if_gnt` out 1: fetch accepted this cycle (combinational).
- `if_rvalid` out 1: `if_rdata` valid, one cycle after grant.
- `if_rdata` out 32: fetched instruction word.
- `d_req` in 1: data request, held until granted.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in MEM_BITS: data entry index.
- `d_mode` in 3: funct3 access mode (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- `d_wdata` in DATA_SIZE: store data.
- `d_gnt` out 1: data request accepted this cycle (combinational).
- `d_rvalid` out 1: response valid, one cycle after grant (loads and stores).
- `d_rdata` out DATA_SIZE: load result; 0 for store responses.
- `mem_we` out 1: to memory `we`.
- `mem_addr` out MEM_BITS: to memory `address`.
- `mem_mode` out 3: to memory `mode`.
- `mem_wdata` out DATA_SIZE: to memory `to_write_data`.
- `mem_rdata` in DATA_SIZE: from memory `to_read_data` (combinational read).

## Operation
- Grant logic is combinational from `if_req`, `d_req` and `starve_cnt`:
  - `fetch_prio = (starve_cnt == STARVE_LIMIT)`.
  - `d_gnt = d_req & ~(if_req & fetch_prio)`.
  - `if_gnt = if_req & ~d_gnt`.
  - `if_gnt` and `d_gnt` are never both 1.
- Memory drive:
  - On `d_gnt`: `mem_we = d_we`, `mem_addr = d_addr`, `mem_mode = d_mode`, `mem_wdata = d_wdata`.
  - On `if_gnt`: `mem_we = 0`, `mem_addr = if_addr`, `mem_mode = 3'b110` (32-bit zero-extended).
  - With no grant: all memory outputs are 0, so no write occurs.
- Stores commit inside `memory` at the posedge ending the grant cycle.
- Response registers are loaded at the posedge ending the grant cycle:
  - Fetch grant: `if_rvalid <= 1`, `if_rdata <= mem_rdata[31:0]`.
  - Data load grant: `d_rvalid <= 1`, `d_rdata <= mem_rdata`.
  - Data store grant: `d_rvalid <= 1`, `d_rdata <= 0`.
  - A port not granted has its `rvalid` cleared to 0 on that edge. `rdata` holds its last value.
- `starve_cnt` (4 bits), updated each posedge:
  - `if_req & ~if_gnt`: increment, saturating at `STARVE_LIMIT`.
  - Otherwise (fetch granted or no fetch request): cleared to 0.
- The arbiter applies no checks to address or mode. Address wrap and misalignment are the requesters' concern.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - `if_rvalid = 0`, `d_rvalid = 0`
  - `if_rdata = 0`, `d_rdata = 0`
  - `starve_cnt = 0`
- While `rst_n` is low, the grants still follow requests combinationally. Requesters must hold `if_req`/`d_req` low during reset.
- Reset asserted mid-transaction drops any pending response. No `rvalid` pulse follows the release of reset.
- Handshake: a request is accepted in a cycle where `req & gnt` is true. The requester may change its address or deassert in the next cycle. Back-to-back grants to the same port give one response every cycle.
- Latency: response exactly 1 cycle after the grant cycle; `rvalid` is a single-cycle pulse per grant.
- Simultaneous requests with `starve_cnt < STARVE_LIMIT`: data wins.
- Simultaneous requests with `starve_cnt == STARVE_LIMIT`: fetch wins and the counter clears.
- Worst-case fetch wait under continuous data traffic: `STARVE_LIMIT` cycles of denial, then a grant on the next cycle.

## Test plan
- Reset: pulse `rst_n` low while `if_rvalid` is 1 (between clock edges) -> `if_rvalid` and `d_rvalid` go 0 immediately, `starve_cnt` = 0, no response after release.
- Lone fetch: memory[0x10] = 64'hFFFF_FFFF_8000_0013, `if_req`, `if_addr` = 0x10 -> `if_gnt` = 1 same cycle, `mem_mode` = 110, next cycle `if_rvalid` = 1 and `if_rdata` = 32'h8000_0013.
- Store then load: `d_req`, `d_we` = 1, `d_mode` = 000, `d_addr` = 5, `d_wdata` = 0xAB -> `d_rvalid` with `d_rdata` = 0. Then a load with `d_mode` = 000 at addr 5 -> `d_rdata` = 64'hFFFF_FFFF_FFFF_FFAB. Same load with `d_mode` = 100 -> 64'hAB.
- Contention: `if_req` and `d_req` both held high, STARVE_LIMIT = 4 -> `d_gnt` on cycles 0-3, `if_gnt` on cycle 4, `d_gnt` on cycles 5-8, `if_gnt` on cycle 9; grants are never simultaneous.
- Idle: no requests for 10 cycles -> `mem_we` = 0, both `rvalid` = 0, memory contents unchanged.
- Counter clear: fetch denied 2 cycles, then `d_req` drops -> fetch granted, `starve_cnt` returns to 0, next contention restarts the 4-cycle count.
